// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side frame decoder:
// FSM state encoding, error codes and the default sync byte.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_HUNT    = 3'd0,
      ST_LEN     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CHECK   = 3'd3,
      ST_DRAIN   = 3'd4
   } state_t;

   typedef logic [1:0] err_code_t;

   localparam err_code_t ERR_LEN     = 2'd0;
   localparam err_code_t ERR_CSUM    = 2'd1;
   localparam err_code_t ERR_LINE    = 2'd2;
   localparam err_code_t ERR_TIMEOUT = 2'd3;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_idle_timer.sv
// Idle-gap watchdog: counts enabled clocks since the last clear and
// flags expiry once TIMEOUT_CLKS-1 is reached. Shared with the TX side.
module uart_idle_timer #(
   parameter int TIMEOUT_CLKS = 104160
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CLKS - 1);

   logic [CW-1:0] count_reg;

   // Count idle clocks while enabled; saturate at the limit until cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable && (count_reg != LIMIT)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign expired = enable && (count_reg == LIMIT);

endmodule

// File: rtl/uart_rx_packet_decoder.sv
// Frame decoder behind the UART receiver: SYNC, LEN, payload, XOR CSUM.
// Payload is buffered and only released over valid/ready once verified.
module uart_rx_packet_decoder
   import uart_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE       = DEFAULT_SYNC_BYTE,
   parameter int          MAX_PAYLOAD_LEN = 16,
   parameter int          TIMEOUT_CLKS    = 104160
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_data_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_error,
   output logic       payload_valid,
   output logic [7:0] payload_data,
   output logic       payload_last,
   input  logic       payload_ready,
   output logic       frame_ok,
   output logic       frame_error,
   output logic [1:0] error_code,
   output logic       overrun,
   output logic       busy
);

   localparam int IW = $clog2(MAX_PAYLOAD_LEN + 1);
   localparam int AW = $clog2(MAX_PAYLOAD_LEN);

   state_t          state_reg, state_next;
   logic [IW-1:0]   len_reg, wr_idx_reg, rd_idx_reg;
   logic [7:0]      xor_reg;
   logic [7:0]      buffer [0:(1<<AW)-1];
   logic            rx_error_prev_reg;
   logic            frame_ok_reg, frame_error_reg, overrun_reg;
   err_code_t       error_code_reg;

   logic            line_err_rise, len_valid, last_write, last_read, xfer;
   logic            ok_event, err_event, buf_we;
   err_code_t       err_code_event;
   logic            timer_clear, timer_enable, timer_expired;

   assign line_err_rise = rx_error && !rx_error_prev_reg;
   assign len_valid     = (rx_data != 8'd0) && (int'(rx_data) <= MAX_PAYLOAD_LEN);
   assign last_write    = (wr_idx_reg == len_reg - 1'b1);
   assign last_read     = (rd_idx_reg == len_reg - 1'b1);
   assign xfer          = payload_valid && payload_ready;
   assign buf_we        = (state_reg == ST_PAYLOAD) && rx_data_ready && !line_err_rise;

   // Idle counter restarts on every byte and on every state change.
   assign timer_clear  = rx_data_ready || (state_next != state_reg);
   assign timer_enable = (state_reg == ST_LEN) || (state_reg == ST_PAYLOAD) ||
                         (state_reg == ST_CHECK);

   uart_idle_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) idle_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_HUNT;
      else        state_reg <= state_next;
   end

   // Next-state and frame verdict; line error beats byte strobe beats timeout.
   always_comb begin
      state_next     = state_reg;
      ok_event       = 1'b0;
      err_event      = 1'b0;
      err_code_event = ERR_LEN;
      unique case (state_reg)
         ST_HUNT: begin
            if (rx_data_ready && (rx_data == SYNC_BYTE)) state_next = ST_LEN;
         end
         ST_LEN, ST_PAYLOAD, ST_CHECK: begin
            if (line_err_rise) begin
               err_event      = 1'b1;
               err_code_event = ERR_LINE;
               state_next     = ST_HUNT;
            end else if (rx_data_ready) begin
               if (state_reg == ST_LEN) begin
                  if (len_valid) begin
                     state_next = ST_PAYLOAD;
                  end else begin
                     err_event      = 1'b1;
                     err_code_event = ERR_LEN;
                     state_next     = ST_HUNT;
                  end
               end else if (state_reg == ST_PAYLOAD) begin
                  if (last_write) state_next = ST_CHECK;
               end else if (rx_data == xor_reg) begin
                  ok_event   = 1'b1;
                  state_next = ST_DRAIN;
               end else begin
                  err_event      = 1'b1;
                  err_code_event = ERR_CSUM;
                  state_next     = ST_HUNT;
               end
            end else if (timer_expired) begin
               err_event      = 1'b1;
               err_code_event = ERR_TIMEOUT;
               state_next     = ST_HUNT;
            end
         end
         ST_DRAIN: begin
            if (xfer && last_read) state_next = ST_HUNT;
         end
         default: state_next = ST_HUNT;
      endcase
   end

   // Stream-side outputs decoded from the current state; data forced to 0 when idle.
   always_comb begin
      busy          = (state_reg != ST_HUNT);
      payload_valid = (state_reg == ST_DRAIN);
      payload_last  = payload_valid && last_read;
      payload_data  = payload_valid ? buffer[rd_idx_reg[AW-1:0]] : 8'h00;
   end

   // Length, running XOR, indices and the registered status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_reg           <= '0;
         wr_idx_reg        <= '0;
         rd_idx_reg        <= '0;
         xor_reg           <= 8'h00;
         rx_error_prev_reg <= 1'b0;
         frame_ok_reg      <= 1'b0;
         frame_error_reg   <= 1'b0;
         overrun_reg       <= 1'b0;
         error_code_reg    <= ERR_LEN;
      end else begin
         rx_error_prev_reg <= rx_error;
         frame_ok_reg      <= ok_event;
         frame_error_reg   <= err_event;
         overrun_reg       <= (state_reg == ST_DRAIN) && rx_data_ready;
         if (err_event) error_code_reg <= err_code_event;
         if ((state_reg == ST_LEN) && rx_data_ready && !line_err_rise && len_valid) begin
            len_reg    <= rx_data[IW-1:0];
            xor_reg    <= rx_data;
            wr_idx_reg <= '0;
         end
         if (buf_we) begin
            xor_reg    <= xor_reg ^ rx_data;
            wr_idx_reg <= wr_idx_reg + 1'b1;
         end
         if (ok_event)  rd_idx_reg <= '0;
         else if (xfer) rd_idx_reg <= rd_idx_reg + 1'b1;
      end
   end

   // Payload store; contents are don't-care after reset so no reset term.
   always_ff @(posedge clk) begin
      if (buf_we) buffer[wr_idx_reg[AW-1:0]] <= rx_data;
   end

   assign frame_ok    = frame_ok_reg;
   assign frame_error = frame_error_reg;
   assign error_code  = error_code_reg;
   assign overrun     = overrun_reg;

endmodule

// File: tb/tb_uart_rx_packet_decoder.sv
// Directed plus randomized frames against a frame-level reference model.
module tb_uart_rx_packet_decoder;

   localparam int T    = 40;
   localparam int MAXL = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_data_ready = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_error = 1'b0;
   logic       payload_ready_drv = 1'b1;
   logic       rand_ready = 1'b0;
   logic       rand_bit = 1'b1;
   logic       ready_eff;
   logic       payload_valid, payload_last, frame_ok, frame_error, overrun, busy;
   logic [7:0] payload_data;
   logic [1:0] error_code;

   int checks = 0;
   int errors = 0;

   // monitor state (written only by the monitor)
   int         cyc = 0, ok_cnt = 0, err_cnt = 0, ovr_cnt = 0, ok_cyc = 0;
   logic [1:0] seen_code = 2'd0;
   logic [7:0] out_q[$];
   bit         last_q[$];
   int         xcyc_q[$];

   // stimulus state (written only by the main initial block)
   logic [7:0] tx_q[$];
   logic [7:0] exp_q[$];
   int ok0, er0, ov0, qb;

   assign ready_eff = rand_ready ? rand_bit : payload_ready_drv;

   always #5 clk = ~clk;

   uart_rx_packet_decoder #(.SYNC_BYTE(8'hA5), .MAX_PAYLOAD_LEN(MAXL), .TIMEOUT_CLKS(T)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
      .rx_error(rx_error), .payload_valid(payload_valid), .payload_data(payload_data),
      .payload_last(payload_last), .payload_ready(ready_eff), .frame_ok(frame_ok),
      .frame_error(frame_error), .error_code(error_code), .overrun(overrun), .busy(busy)
   );

   always @(posedge clk) begin
      #1;
      rand_bit = 1'($urandom_range(0, 1));
   end

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (frame_ok) begin ok_cnt = ok_cnt + 1; ok_cyc = cyc; end
      if (frame_error) begin err_cnt = err_cnt + 1; seen_code = error_code; end
      if (overrun) ovr_cnt = ovr_cnt + 1;
      if (payload_valid && ready_eff) begin
         out_q.push_back(payload_data);
         last_q.push_back(payload_last);
         xcyc_q.push_back(cyc);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data = b;
      rx_data_ready = 1'b1;
      step();
      rx_data_ready = 1'b0;
      repeat (gap) step();
   endtask

   task automatic send_tx(input int maxgap);
      for (int i = 0; i < tx_q.size(); i++)
         send_byte(tx_q[i], (i == tx_q.size() - 1) ? 0 : $urandom_range(0, maxgap));
   endtask

   task automatic snap();
      ok0 = ok_cnt; er0 = err_cnt; ov0 = ovr_cnt; qb = out_q.size();
   endtask

   task automatic check_zero(input string tag);
      check(tag, {payload_valid, payload_data, payload_last, frame_ok, frame_error,
                  error_code, overrun, busy}, 32'd0);
   endtask

   // Build SYNC, LEN, payload, CSUM; exp_q holds what a good frame must stream.
   task automatic build(input int len, input bit corrupt);
      logic [7:0] cs, b;
      tx_q.delete(); exp_q.delete();
      tx_q.push_back(8'hA5);
      tx_q.push_back(8'(len));
      if (len < 1 || len > MAXL) return;
      cs = 8'(len);
      for (int i = 0; i < len; i++) begin
         b = 8'($urandom_range(0, 255));
         tx_q.push_back(b); exp_q.push_back(b); cs = cs ^ b;
      end
      if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
      tx_q.push_back(cs);
   endtask

   task automatic finish_frame(input string tag, input bit exp_ok, input logic [1:0] exp_code,
                               input bit consec);
      int n, nx;
      n = 0;
      while ((ok_cnt + err_cnt) == (ok0 + er0) && n < 400) begin step(); n++; end
      n = 0;
      while (exp_ok && (out_q.size() - qb) < exp_q.size() && n < 2000) begin step(); n++; end
      repeat (3) step();
      check({tag, "_ok"}, ok_cnt - ok0, {31'd0, exp_ok});
      check({tag, "_err"}, err_cnt - er0, {31'd0, !exp_ok});
      if (!exp_ok) check({tag, "_code"}, error_code, exp_code);
      nx = exp_ok ? exp_q.size() : 0;
      check({tag, "_count"}, out_q.size() - qb, nx);
      for (int i = 0; i < nx && qb + i < out_q.size(); i++) begin
         check({tag, "_data"}, out_q[qb + i], exp_q[i]);
         check({tag, "_last"}, last_q[qb + i], (i == nx - 1));
         if (consec) check({tag, "_cyc"}, xcyc_q[qb + i], ok_cyc + i);
      end
      check({tag, "_busy"}, busy, 1'b0);
   endtask

   task automatic set_tx(input logic [7:0] a[]);
      tx_q.delete();
      foreach (a[i]) tx_q.push_back(a[i]);
   endtask

   task automatic set_exp(input logic [7:0] a[]);
      exp_q.delete();
      foreach (a[i]) exp_q.push_back(a[i]);
   endtask

   initial begin
      int len;
      bit corrupt, bad;
      // reset state
      repeat (3) step();
      check_zero("reset_outputs");
      rst_n = 1'b1;
      step();

      // good frame
      snap(); set_tx('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}); set_exp('{8'h11, 8'h22, 8'h33});
      send_tx(2); finish_frame("good", 1, 2'd0, 1);

      // garbage then bad checksum, then a good frame
      snap(); set_tx('{8'h00, 8'hFF, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04});
      send_tx(1); finish_frame("bad_csum", 0, 2'd1, 0);
      snap(); set_tx('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}); set_exp('{8'h11, 8'h22, 8'h33});
      send_tx(1); finish_frame("good_after", 1, 2'd0, 1);

      // length bounds
      snap(); build(0, 0); send_tx(0); finish_frame("len_zero", 0, 2'd0, 0);
      snap(); build(17, 0); send_tx(0); finish_frame("len_17", 0, 2'd0, 0);
      snap(); build(16, 0); send_tx(1); finish_frame("len_16", 1, 2'd0, 1);

      // timeout exactly T idle clocks after the last byte
      snap(); set_tx('{8'hA5, 8'h02, 8'h11}); send_tx(0);
      repeat (T - 1) step();
      check("timeout_early", frame_error, 1'b0);
      step();
      check("timeout_pulse", frame_error, 1'b1);
      check("timeout_code", error_code, 2'd3);
      repeat (3) step();

      // line error rising after SYNC LEN
      snap(); set_tx('{8'hA5, 8'h02}); send_tx(0);
      rx_error = 1'b1;
      step();
      check("line_pulse", frame_error, 1'b1);
      check("line_code", error_code, 2'd2);
      repeat (5) step();
      rx_error = 1'b0;
      step();
      check("line_err_count", err_cnt - er0, 1);

      // backpressure and overrun
      payload_ready_drv = 1'b0;
      snap(); set_tx('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}); send_tx(0);
      for (int k = 0; k < 5; k++) begin
         check("hold_valid", payload_valid, 1'b1);
         check("hold_data", payload_data, 8'h11);
         check("hold_last", payload_last, 1'b0);
         if (k == 2) send_byte(8'hA5, 0);
         else step();
      end
      check("overrun_count", ovr_cnt - ov0, 1);
      payload_ready_drv = 1'b1;
      set_exp('{8'h11, 8'h22, 8'h33});
      finish_frame("backpressure", 1, 2'd0, 0);

      // reset mid-PAYLOAD
      set_tx('{8'hA5, 8'h03, 8'h11}); send_tx(0);
      rst_n = 1'b0; #1;
      check_zero("reset_payload");
      step(); rst_n = 1'b1; step();

      // reset mid-DRAIN
      payload_ready_drv = 1'b0;
      set_tx('{8'hA5, 8'h02, 8'h44, 8'h55, 8'h13}); send_tx(0);
      check("drain_before_reset", payload_valid, 1'b1);
      rst_n = 1'b0; #1;
      check_zero("reset_drain");
      step(); rst_n = 1'b1; payload_ready_drv = 1'b1; step();
      snap(); set_tx('{8'hA5, 8'h01, 8'h7E, 8'h7F}); set_exp('{8'h7E});
      send_tx(0); finish_frame("after_reset", 1, 2'd0, 1);

      // randomized frames against the frame-level model
      for (int f = 0; f < 24; f++) begin
         if ($urandom_range(0, 7) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255);
         else len = $urandom_range(1, MAXL);
         corrupt = ($urandom_range(0, 3) == 0);
         bad = (len < 1 || len > MAXL);
         rand_ready = (f % 2 == 1);
         snap(); build(len, corrupt); send_tx(3);
         finish_frame("random", !bad && !corrupt, bad ? 2'd0 : 2'd1, 1'(!rand_ready));
         rand_ready = 1'b0;
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
